// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
// Converts whole 256-bit cacheline read/write requests from the cache into
// 4-beat, 64-bit bursts on the physical memory port. It returns the assembled
// line and a one-cycle resp_o to the cache.
//
// Optional feature: define CACHELINE_ADAPTOR_EARLY_RESP_EN to remove the DONE
// state. With it defined, resp_o fires in the same cycle as the final memory
// beat, and line_o forwards that beat combinationally for that cycle only.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [1:0]      count;
  logic [3:0][63:0] wbuf;      // write line, frozen from accept to completion
  logic [191:0]    asm_buf;    // read beats 0..2 while the line is assembling
  logic [255:0]    line_q;     // last completed read line
  logic            last_beat;

  // The fourth beat of a burst is being strobed this cycle.
  assign last_beat = resp_i && (count == 2'd3);

`ifndef CACHELINE_ADAPTOR_EARLY_RESP_EN
  logic resp_q;
`endif

  // Main FSM: sequencing, beat counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, whatever the statement order.
      state     <= IDLE;
      count     <= 2'd0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      address_o <= 32'd0;
      burst_o   <= 64'd0;
      line_q    <= 256'd0;
`ifndef CACHELINE_ADAPTOR_EARLY_RESP_EN
      resp_q    <= 1'b0;
`endif
    end else begin
`ifndef CACHELINE_ADAPTOR_EARLY_RESP_EN
      resp_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          // A write wins when both requests are high.
          if (write_i) begin
            state     <= WRITE;
            write_o   <= 1'b1;
            address_o <= {address_i[31:5], 5'b0};
            burst_o   <= line_i[63:0];
            count     <= 2'd0;
          end else if (read_i) begin
            state     <= READ;
            read_o    <= 1'b1;
            address_o <= {address_i[31:5], 5'b0};
            count     <= 2'd0;
          end
        end

        READ: begin
          if (resp_i) begin
            count <= count + 2'd1;
            if (count == 2'd3) begin
              read_o <= 1'b0;
              line_q <= {burst_i, asm_buf};
`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
              state  <= IDLE;
`else
              state  <= DONE;
              resp_q <= 1'b1;
`endif
            end
          end
        end

        WRITE: begin
          if (resp_i) begin
            count <= count + 2'd1;
            if (count == 2'd3) begin
              write_o <= 1'b0;
              burst_o <= 64'd0;
`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
              state   <= IDLE;
`else
              state   <= DONE;
              resp_q  <= 1'b1;
`endif
            end else begin
              burst_o <= wbuf[count + 2'd1];
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  // Datapath buffers: write line capture and read beat assembly.
  // NOTE: these buffers are deliberately not reset. Each is fully rewritten
  // before it is used, and line_q (the visible line) is reset instead.
  always_ff @(posedge clk) begin
    if (state == IDLE && write_i) begin
      wbuf <= line_i;
    end
    if (state == READ && resp_i) begin
      unique case (count)
        2'd0:    asm_buf[63:0]    <= burst_i;
        2'd1:    asm_buf[127:64]  <= burst_i;
        2'd2:    asm_buf[191:128] <= burst_i;
        default: ;
      endcase
    end
  end

`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
  assign resp_o = ((state == READ) || (state == WRITE)) && last_beat;
  assign line_o = (state == READ && last_beat) ? {burst_i, asm_buf} : line_q;
`else
  assign resp_o = resp_q;
  assign line_o = line_q;
`endif

endmodule
